// File: rtl/instr_sequencer_if.sv
// Instruction sequencer bus bundle.
// Carries the run request, the instruction-memory and data-memory
// handshakes, and the decoded fields and status flags produced by the
// sequencer.
//   master : the sequencer side (drives requests, pc, decode fields, status)
//   slave  : the memory / control side (drives run, acks and read data)
interface instr_sequencer_if;
  logic       run;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] pc;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic [7:0] dmem_rdata;
  logic [7:0] dmem_addr;
  logic [7:0] load_data;
  logic [2:0] opcode;
  logic [1:0] rd_sel;
  logic [1:0] rs_sel;
  logic       reg_wr_en;
  logic       busy;
  logic       instr_done;

  modport master (
    input  run, imem_ack, imem_rdata, dmem_ack, dmem_rdata,
    output imem_req, pc, dmem_req, dmem_we, dmem_addr, load_data,
           opcode, rd_sel, rs_sel, reg_wr_en, busy, instr_done
  );

  modport slave (
    output run, imem_ack, imem_rdata, dmem_ack, dmem_rdata,
    input  imem_req, pc, dmem_req, dmem_we, dmem_addr, load_data,
           opcode, rd_sel, rs_sel, reg_wr_en, busy, instr_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer.
// Fetches one instruction byte per instruction from instruction memory,
// decodes it, fetches a second operand byte for load/store, performs the
// data-memory access and retires through a one-cycle write-back.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_sequencer_if master modport (run, imem/dmem handshakes,
//           pc, dmem_addr, load_data, opcode/rd_sel/rs_sel, reg_wr_en,
//           busy, instr_done)
module instr_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    FETCH2,
    MEM,
    WB
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b111;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  // IR bit 0 carries no decode meaning, so only bits 7:1 are kept.
  logic [7:1] ir_q, ir_d;
  logic [7:0] dmem_addr_q, dmem_addr_d;
  logic [7:0] load_data_q, load_data_d;

  logic imem_req;
  logic dmem_req;
  logic dmem_we;
  logic reg_wr_en;
  logic instr_done;
  logic is_mem;
  logic is_store;

  assign is_store = (ir_q[7:5] == OP_STORE);
  assign is_mem   = (ir_q[7:5] == OP_LOAD) || is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      dmem_addr_q <= 8'h00;
      load_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      dmem_addr_q <= dmem_addr_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    dmem_addr_d = dmem_addr_q;
    load_data_d = load_data_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_wr_en   = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata[7:1];
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = is_mem ? FETCH2 : WB;
      end

      FETCH2: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          dmem_addr_d = bus.imem_rdata;
          pc_d        = pc_q + 8'd1;
          state_d     = MEM;
        end
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (bus.dmem_ack) begin
          if (is_store) begin
            // A store retires directly from its acked MEM cycle.
            instr_done = 1'b1;
            state_d    = bus.run ? FETCH : IDLE;
          end else begin
            load_data_d = bus.dmem_rdata;
            state_d     = WB;
          end
        end
      end

      WB: begin
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
        state_d    = bus.run ? FETCH : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.reg_wr_en  = reg_wr_en;
  assign bus.instr_done = instr_done;
  assign bus.busy       = (state_q != IDLE);
  assign bus.pc         = pc_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.load_data  = load_data_q;
  assign bus.opcode     = ir_q[7:5];
  assign bus.rd_sel     = ir_q[4:3];
  assign bus.rs_sel     = ir_q[2:1];

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 run  input  1  SHALL request instruction execution while high.
REQ-005 imem_req  output  1  SHALL request an instruction-memory byte at address pc.
REQ-006 imem_ack  input  1  SHALL indicate imem_rdata valid for the current request.
REQ-007 imem_rdata  input  8  SHALL be the instruction-memory byte.
REQ-008 pc  output  8  SHALL be the program counter.
REQ-009 dmem_req  output  1  SHALL request a data-memory access at dmem_addr.
REQ-010 dmem_we  output  1  SHALL mark the dmem access as a write (store).
REQ-011 dmem_ack  input  1  SHALL complete the dmem access.
REQ-012 dmem_rdata  input  8  SHALL be the load data.
REQ-013 dmem_addr  output  8  SHALL be the latched operand byte of load/store.
REQ-014 load_data  output  8  SHALL hold dmem_rdata captured on load completion.
REQ-015 opcode  output  3  SHALL drive the control unit's opCode (IR[7:5]).
REQ-016 rd_sel, rs_sel  output  2 each  SHALL be IR[4:3] and IR[2:1].
REQ-017 reg_wr_en  output  1  SHALL gate the control unit's regWrite; high only in WB.
REQ-018 busy  output  1  SHALL be high in every state except IDLE.
REQ-019 instr_done  output  1  SHALL pulse one cycle as each instruction retires.

Function
REQ-020 States SHALL be IDLE, FETCH, DECODE, FETCH2, MEM, WB.
REQ-021 IDLE: run=1 -> FETCH next cycle; run=0 -> stay.
REQ-022 FETCH: imem_req=1 held until a cycle with imem_ack=1; that edge loads IR<=imem_rdata, pc<=pc+1, -> DECODE.
REQ-023 DECODE (1 cycle): opcode 000 (load) or 111 (store) -> FETCH2; all others -> WB.
REQ-024 FETCH2: imem_req=1 until imem_ack; on ack dmem_addr<=imem_rdata, pc<=pc+1, -> MEM.
REQ-025 MEM: dmem_req=1, dmem_we=(opcode==111) until dmem_ack; on ack load -> WB with load_data<=dmem_rdata; store -> retire.
REQ-026 WB (1 cycle): reg_wr_en=1, then retire.
REQ-027 Retire SHALL pulse instr_done on the final cycle of WB or of the store's acked MEM cycle, then go to FETCH if run=1 else IDLE.
REQ-028 run SHALL be sampled only in IDLE and at retire; deassertion mid-instruction completes that instruction.
REQ-029 Minimum latency FETCH-entry to instr_done: ALU/mov 3 cycles, store 4, load 5; each ack wait adds one cycle per stall.
REQ-030 pc SHALL wrap 8'hFF -> 8'h00 modulo 256, including between FETCH and FETCH2.
REQ-031 imem_req and dmem_req SHALL never be high in the same cycle.
REQ-032 Ack arriving in the first req cycle SHALL complete the access in that cycle; ack with req low SHALL be ignored.
REQ-033 req SHALL be low the cycle after its ack (state has advanced).
REQ-034 pc, IR, dmem_addr, load_data SHALL persist through IDLE.

Reset
REQ-035 On rst_n=0, immediately and regardless of state: state=IDLE, pc=RESET_PC, IR=8'h00, dmem_addr=8'h00, load_data=8'h00, all req/we/reg_wr_en/instr_done=0, busy=0.
REQ-036 Reset mid-access SHALL abandon it; no retire, no register write.
REQ-037 After rst_n rises, first FETCH SHALL occur one cycle after run=1 is sampled in IDLE.

Verification
REQ-038 run=1, zero-wait acks, imem[0]=8'h4A (add) -> imem_req cycle 1, reg_wr_en cycle 3, instr_done cycle 3, opcode=010, rd_sel=01, rs_sel=01, pc=1.
REQ-039 Load imem[0]=8'h00, imem[1]=8'h3C, dmem[3C]=8'hA5, dmem_ack 2-cycle stall -> dmem_addr=3C, load_data=A5, reg_wr_en one cycle, instr_done 7 cycles after FETCH entry, pc=2.
REQ-040 Store 8'hE0 then 8'h10 -> dmem_req=1 with dmem_we=1 and dmem_addr=10, reg_wr_en never 1, instr_done 4 cycles after FETCH entry.
REQ-041 pc=8'hFF, load instruction -> operand fetched from 8'h00, pc=8'h01 at retire.
REQ-042 run dropped during FETCH2 -> instruction completes, instr_done pulses, state IDLE, busy=0, no further imem_req.
REQ-043 rst_n=0 asserted during MEM with dmem_req=1 -> dmem_req=0 same cycle, pc=RESET_PC, no instr_done.
